// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder types: received symbol pair and ACS sequencer states.
package viterbi_pkg;

  typedef logic [1:0] sym_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACS     = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_TB_WAIT = 2'd3
  } acs_state_t;

endpackage

// File: rtl/acs_seq_ctrl.sv
// Sequences one frame of received symbols through the ACS array and survivor
// memory, then launches traceback and waits for it to finish.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a symbol flagged frame_start
// ST_ACS     | accepting symbols, one survivor write per accepted symbol
// ST_FLUSH   | final survivor write visible, input stalled
// ST_TB_WAIT | traceback launched, waiting for tb_done
module acs_seq_ctrl
  import viterbi_pkg::*;
#(
  parameter  int FRAME_LEN = 256,
  localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  sym_pair_t         rx_pair,
  input  logic              frame_start,
  output sym_pair_t         bm_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tb_start,
  input  logic              tb_done,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  acs_state_t        state, state_nx;
  logic [ADDR_W-1:0] count, count_nx;
  sym_pair_t         bm_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              en_nx, init_nx, wr_nx, tbs_nx, err_nx;
  logic [7:0]        fcnt_nx;
  logic              accept;

  assign in_ready = (state == ST_IDLE) || (state == ST_ACS);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      bm_pair   <= '0;
      mem_addr  <= '0;
      acs_en    <= 1'b0;
      acs_init  <= 1'b0;
      mem_wr    <= 1'b0;
      tb_start  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      bm_pair   <= bm_nx;
      mem_addr  <= addr_nx;
      acs_en    <= en_nx;
      acs_init  <= init_nx;
      mem_wr    <= wr_nx;
      tb_start  <= tbs_nx;
      frame_err <= err_nx;
      busy      <= (state_nx != ST_IDLE);
      frame_cnt <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    bm_nx    = bm_pair;
    addr_nx  = mem_addr;
    en_nx    = 1'b0;
    init_nx  = 1'b0;
    wr_nx    = 1'b0;
    tbs_nx   = 1'b0;
    err_nx   = 1'b0;
    fcnt_nx  = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (accept && frame_start) begin
          state_nx = ST_ACS;
          count_nx = ADDR_W'(1);
          bm_nx    = rx_pair;
          addr_nx  = '0;
          en_nx    = 1'b1;
          init_nx  = 1'b1;
          wr_nx    = 1'b1;
        end
      end
      ST_ACS: begin
        if (accept) begin
          bm_nx = rx_pair;
          en_nx = 1'b1;
          wr_nx = 1'b1;
          // A new frame_start mid-frame abandons the partial frame.
          if (frame_start) begin
            err_nx   = 1'b1;
            count_nx = ADDR_W'(1);
            addr_nx  = '0;
            init_nx  = 1'b1;
          end else begin
            addr_nx  = count;
            count_nx = count + 1'b1;
            if (count == LAST_IDX) state_nx = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        state_nx = ST_TB_WAIT;
        tbs_nx   = 1'b1;
      end
      ST_TB_WAIT: begin
        if (tb_done) begin
          state_nx = ST_IDLE;
          count_nx = '0;
          fcnt_nx  = frame_cnt + 8'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: doc/acs_seq_ctrl.md
ACS_SEQ_CTRL -- requirements
Module: acs_seq_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, meaning symbols per frame; legal values are powers of two, 4 to 1024.
REQ-002 SHALL have derived parameter ADDR_W = $clog2(FRAME_LEN), meaning survivor-memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a received symbol pair is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts a symbol this cycle.
REQ-007 SHALL have port rx_pair, input, 2 bits: received channel bit pair.
REQ-008 SHALL have port frame_start, input, 1 bit: qualifies the current symbol as first of a frame.
REQ-009 SHALL have port bm_pair, output, 2 bits: registered symbol driven to the branch-metric units.
REQ-010 SHALL have port acs_en, output, 1 bit: ACS array updates path metrics this cycle.
REQ-011 SHALL have port acs_init, output, 1 bit: ACS array loads initial metrics (state 0 = 0, others max).
REQ-012 SHALL have port mem_wr, output, 1 bit: survivor-memory write strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits: survivor-memory write address.
REQ-014 SHALL have port tb_start, output, 1 bit: one-cycle traceback launch pulse.
REQ-015 SHALL have port tb_done, input, 1 bit: traceback finished.
REQ-016 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-017 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a mid-frame restart.
REQ-018 SHALL have port frame_cnt, output, 8 bits: count of completed frames, wrapping at 255 to 0.

Function
REQ-019 SHALL be a four-state FSM: IDLE, ACS, FLUSH, TB_WAIT.
REQ-020 SHALL register all outputs except in_ready, which is combinational from the current state.
REQ-021 SHALL drive in_ready = 1 in IDLE and ACS, and 0 in FLUSH and TB_WAIT.
REQ-022 SHALL define an accept as in_valid & in_ready at a rising edge.
REQ-023 SHALL, in IDLE, discard accepts without frame_start, with no other output change.
REQ-024 SHALL, on an accept with frame_start in IDLE, move to ACS, set symbol count to 1, and in the next cycle drive bm_pair = rx_pair, acs_en = 1, acs_init = 1, mem_wr = 1, mem_addr = 0.
REQ-025 SHALL, on each ACS accept with count k, drive in the next cycle bm_pair = rx_pair, acs_en = 1, acs_init = 0, mem_wr = 1, mem_addr = k, and increment the count.
REQ-026 SHALL, on the ACS accept with k = FRAME_LEN-1, move to FLUSH.
REQ-027 SHALL hold acs_en, mem_wr and acs_init low in every cycle not following an accept; bm_pair SHALL hold its last value.
REQ-028 SHALL, on an accept with frame_start in ACS, pulse frame_err, restart the count at 1, and treat the symbol exactly as in REQ-024.
REQ-029 SHALL spend exactly one cycle in FLUSH, during which the final write occurs, then enter TB_WAIT with tb_start = 1 for that first TB_WAIT cycle only.
REQ-030 SHALL sample tb_done only in TB_WAIT, including its first cycle; tb_done SHALL return the FSM to IDLE at the next edge and increment frame_cnt.
REQ-031 SHALL ignore tb_done in IDLE, ACS and FLUSH.
REQ-032 SHALL have a latency of 1 cycle from accept to acs_en, and FRAME_LEN+1 cycles minimum from the first accept to tb_start for gap-free input.

Reset
REQ-033 SHALL, when rst is low, immediately force state to IDLE, count to 0, frame_cnt to 0, bm_pair to 0, mem_addr to 0, and acs_en, acs_init, mem_wr, tb_start, frame_err to 0.
REQ-034 SHALL, on reset asserted mid-frame or mid-traceback, discard the partial frame; the first post-reset frame requires frame_start.

Structure
REQ-035 SHALL import state enum acs_state_t from shared package viterbi_pkg, which also holds the symbol pair typedef sym_pair_t.
REQ-036 SHALL contain no sub-modules; the branch-metric, ACS, survivor-memory and traceback blocks are instantiated by the parent decoder.

Verification
REQ-037 SHALL verify, with FRAME_LEN=4 and four gap-free symbols (frame_start on the first): mem_addr 0,1,2,3 on consecutive cycles; acs_init only with addr 0; tb_start 2 cycles after the last accept.
REQ-038 SHALL verify that in_valid without frame_start in IDLE causes no acs_en or mem_wr and busy stays 0.
REQ-039 SHALL verify that frame_start on the third symbol of a frame gives a frame_err pulse, and the next write uses mem_addr 0 with acs_init = 1.
REQ-040 SHALL verify that tb_done asserted in the same cycle as tb_start returns the FSM to IDLE next cycle and frame_cnt becomes 1.
REQ-041 SHALL verify that in_valid held high through FLUSH and TB_WAIT sees in_ready = 0 and no symbol is accepted.
REQ-042 SHALL verify that rst low in ACS after 2 symbols clears all outputs asynchronously, that the following frame starts at mem_addr 0, and that 256 frames wrap frame_cnt to 0.
